datapath_calc: RTL and testbench
================================

DATAPATH_CALC -- requirements
Module: datapath_calc

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 muestra  input  16  signed Q8.8 input sample.
REQ-004 muestra_valida  input  1  one-cycle strobe; muestra valid this cycle.
REQ-005 Bandera  output  1  one-cycle start pulse to sequencer.
REQ-006 sel_const  input  3  constant index from sequencer, 0..5 valid.
REQ-007 sel_fun  input  2  function-unit select from sequencer.
REQ-008 sel_acum  input  2  accumulator select from sequencer.
REQ-009 Senal  input  1  snapshot strobe from sequencer.
REQ-010 Band_Listo  input  1  sequence-complete strobe from sequencer.
REQ-011 y_out  output  16  signed Q8.8 result, held until next result.
REQ-012 y_aux  output  16  signed Q8.8 intermediate snapshot.
REQ-013 y_valida  output  1  one-cycle pulse; y_out updated this cycle.
REQ-014 ocupado  output  1  high from Bandera until Band_Listo.
REQ-015 sobrecarga  output  1  sticky overrun flag.

Function
REQ-016 States IDLE and BUSY; ocupado SHALL equal (state==BUSY).
REQ-017 In IDLE, muestra_valida SHALL latch muestra into x_r, pulse Bandera for exactly one cycle, and move to BUSY on the same edge.
REQ-018 In BUSY, muestra_valida SHALL be ignored and SHALL set sobrecarga; x_r is unchanged.
REQ-019 In BUSY, Band_Listo SHALL return to IDLE; y_out SHALL load the accumulator value produced by that same edge; y_valida SHALL pulse on the following cycle (y_out stable while y_valida high).
REQ-020 Band_Listo in IDLE SHALL be ignored, with no y_out update and no y_valida pulse.
REQ-021 Constant K = table[sel_const]; sel_const 6 or 7 SHALL yield K = 0.
REQ-022 Function unit, registered into prod_r each cycle in BUSY: 00 prod_r<=K; 01 prod_r<=acc*K; 10 prod_r<=x_r*K; 11 prod_r<=prod_r*K.
REQ-023 Accumulator, each cycle in BUSY, using the pre-edge prod_r: 00 acc<=acc+prod_r; 01 acc<=prod_r; 10 acc<=0; 11 hold.
REQ-024 Q8.8 multiply: 32-bit signed product, arithmetic shift right 8, then reduce to 16 bits per REQ-030/031.
REQ-025 Senal high in BUSY SHALL load y_aux with the pre-edge acc.
REQ-026 In IDLE, prod_r and acc SHALL hold regardless of selects.
REQ-027 Simultaneous muestra_valida and Band_Listo in BUSY: return to IDLE and set sobrecarga; the sample is dropped.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, Bandera=0, y_valida=0, ocupado=0, sobrecarga=0, and y_out, y_aux, x_r, prod_r, acc = 0.
REQ-029 Reset mid-sequence SHALL abandon the sequence with no y_valida; the next muestra_valida after release SHALL start normally.

Configuration
REQ-030 With DATAPATH_SAT_EN defined, multiply and add results SHALL saturate to 0x7FFF / 0x8000.
REQ-031 Without DATAPATH_SAT_EN, results SHALL wrap (keep low 16 bits); all other behaviour is identical.

Structure
REQ-032 Package datapath_pkg SHALL hold: data width 16, fraction bits 8, constants K0..K5 (0x0100, 0x0080, 0x0040, 0x0200, 0xFF00, 0x0000), and sel_fun/sel_acum encodings.
REQ-033 One sub-module, mult_q88, SHALL implement the Q8.8 multiply with saturate/wrap; it is instantiated once and its operand is muxed.

Verification
REQ-034 muestra=0x0200 with strobe in IDLE -> Bandera pulse, ocupado=1; then selects f=10,c=0,a=11, then a=01 -> acc=0x0200; Band_Listo -> y_out=0x0200, y_valida one cycle later.
REQ-035 x_r=0x0200, f=10,c=3 then a=00 twice from acc=0 -> acc=0x0800.
REQ-036 DATAPATH_SAT_EN: x_r=0x7000, f=10,c=3 -> prod_r=0x7FFF; without the macro -> prod_r=0xE000.
REQ-037 muestra_valida while ocupado=1 -> sobrecarga=1 and remains set; x_r unchanged.
REQ-038 reset_n low between Bandera and Band_Listo -> all outputs 0 immediately, no y_valida; next sample completes normally.
REQ-039 Senal with acc=0x0180 -> y_aux=0x0180; sel_const=7, f=00 -> prod_r=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_calc shared types, Q8.8 constants and result reduction.
// Optional build macro DATAPATH_SAT_EN selects saturation instead of wrap.
package datapath_pkg;

  localparam int DW = 16;
  localparam int FW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FUN_K    = 2'b00,
    FUN_ACC  = 2'b01,
    FUN_X    = 2'b10,
    FUN_PROD = 2'b11
  } fun_e;

  typedef enum logic [1:0] {
    ACC_ADD  = 2'b00,
    ACC_LOAD = 2'b01,
    ACC_CLR  = 2'b10,
    ACC_HOLD = 2'b11
  } acum_e;

  localparam logic signed [DW-1:0] K0 = 16'sh0100;
  localparam logic signed [DW-1:0] K1 = 16'sh0080;
  localparam logic signed [DW-1:0] K2 = 16'sh0040;
  localparam logic signed [DW-1:0] K3 = 16'sh0200;
  localparam logic signed [DW-1:0] K4 = 16'shFF00;
  localparam logic signed [DW-1:0] K5 = 16'sh0000;

  function automatic logic signed [DW-1:0] const_k(
    input logic [2:0] sel
  );
    case (sel)
      3'd0:    return K0;
      3'd1:    return K1;
      3'd2:    return K2;
      3'd3:    return K3;
      3'd4:    return K4;
      3'd5:    return K5;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [DW-1:0] reduce16(
    input logic signed [23:0] v
  );
`ifdef DATAPATH_SAT_EN
    if (v > 24'sd32767)
      return 16'sh7FFF;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return 16'(v);
`else
    return 16'(v);
`endif
  endfunction

endpackage

// File: rtl/datapath_calc_if.sv
// Sequencer/sample bus of datapath_calc.
// master drives sample and selects; slave is the datapath.
interface datapath_calc_if;
  logic [15:0] muestra;
  logic        muestra_valida;
  logic        Bandera;
  logic [2:0]  sel_const;
  logic [1:0]  sel_fun;
  logic [1:0]  sel_acum;
  logic        Senal;
  logic        Band_Listo;
  logic [15:0] y_out;
  logic [15:0] y_aux;
  logic        y_valida;
  logic        ocupado;
  logic        sobrecarga;

  modport master (
    output muestra, muestra_valida,
    output sel_const, sel_fun, sel_acum,
    output Senal, Band_Listo,
    input  Bandera, y_out, y_aux,
    input  y_valida, ocupado, sobrecarga
  );

  modport slave (
    input  muestra, muestra_valida,
    input  sel_const, sel_fun, sel_acum,
    input  Senal, Band_Listo,
    output Bandera, y_out, y_aux,
    output y_valida, ocupado, sobrecarga
  );
endinterface

// File: rtl/datapath_calc_mult_q88.sv
// mult_q88: signed Q8.8 multiply, >>> 8, then 16-bit reduce.
// Reduction is saturate under DATAPATH_SAT_EN, wrap otherwise.
module mult_q88
  import datapath_pkg::*;
(
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic signed [DW-1:0] o_p
);

  logic signed [2*DW-1:0] w_full;
  logic signed [23:0]     w_shr;

  // full product, rescaled; 24 bits hold any 16x16 result
  always_comb begin
    w_full = i_a * i_b;
    w_shr  = 24'(w_full >>> FW);
    o_p    = reduce16(w_shr);
  end

endmodule

// File: rtl/datapath_calc.sv
// datapath_calc: Q8.8 sample datapath driven by an external sequencer.
// Build macro DATAPATH_SAT_EN makes multiply/add saturate.
module datapath_calc
  import datapath_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  datapath_calc_if.slave bus
);

  state_e r_state, w_next;
  logic   w_start, w_step;

  logic signed [DW-1:0] r_x, r_prod, r_acc;
  logic signed [DW-1:0] r_yout, r_yaux;
  logic                 r_band, r_yval, r_sov;

  logic signed [DW-1:0] w_k, w_opa, w_mul;
  logic signed [DW-1:0] w_prod_nxt, w_acc_nxt, w_add;
  logic signed [DW:0]   w_sum;

  assign bus.Bandera    = r_band;
  assign bus.y_out      = r_yout;
  assign bus.y_aux      = r_yaux;
  assign bus.y_valida   = r_yval;
  assign bus.ocupado    = (r_state == ST_BUSY);
  assign bus.sobrecarga = r_sov;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // next state: sample starts a run, Band_Listo ends it
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_step  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.muestra_valida) begin
          w_next  = ST_BUSY;
          w_start = 1'b1;
        end
      end
      ST_BUSY: begin
        w_step = 1'b1;
        if (bus.Band_Listo) w_next = ST_IDLE;
      end
    endcase
  end

  // single multiplier, operand picked by sel_fun
  always_comb begin
    w_k = const_k(bus.sel_const);
    case (fun_e'(bus.sel_fun))
      FUN_ACC: w_opa = r_acc;
      FUN_X:   w_opa = r_x;
      default: w_opa = r_prod;
    endcase
  end

  mult_q88 u_mult (
    .i_a (w_opa),
    .i_b (w_k),
    .o_p (w_mul)
  );

  // next prod_r / acc values for a busy cycle
  always_comb begin
    w_prod_nxt = (fun_e'(bus.sel_fun) == FUN_K) ? w_k : w_mul;
    w_sum = {r_acc[DW-1], r_acc} + {r_prod[DW-1], r_prod};
    w_add = reduce16(24'(w_sum));
    case (acum_e'(bus.sel_acum))
      ACC_ADD:  w_acc_nxt = w_add;
      ACC_LOAD: w_acc_nxt = r_prod;
      ACC_CLR:  w_acc_nxt = '0;
      default:  w_acc_nxt = r_acc;
    endcase
  end

  // datapath registers and output strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_yout <= '0;
      r_yaux <= '0;
      r_band <= 1'b0;
      r_yval <= 1'b0;
      r_sov  <= 1'b0;
    end else begin
      r_band <= w_start;
      r_yval <= 1'b0;
      if (w_start) r_x <= bus.muestra;
      if (w_step) begin
        r_prod <= w_prod_nxt;
        r_acc  <= w_acc_nxt;
        if (bus.Senal)          r_yaux <= r_acc;
        if (bus.muestra_valida) r_sov  <= 1'b1;
        if (bus.Band_Listo) begin
          r_yout <= w_acc_nxt;
          r_yval <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_calc.sv
// Scoreboard bench for datapath_calc against an integer model.
// Follows DATAPATH_SAT_EN for saturate vs wrap expectations.
module tb_datapath_calc;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  datapath_calc_if bus ();

  datapath_calc dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  int ktab[8] = '{256, 128, 64, 512, -256, 0, 0, 0};

  int m_x, m_prod, m_acc, m_aux, m_yout;
  bit m_busy, m_sov, m_band;

  function automatic int fix16(longint v);
    longint w;
    w = v;
`ifdef DATAPATH_SAT_EN
    if (w > 32767) w = 32767;
    if (w < -32768) w = -32768;
`else
    w = w & 64'hFFFF;
    if (w >= 32768) w = w - 65536;
`endif
    return int'(w);
  endfunction

  function automatic int mulq(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return fix16(p >>> 8);
  endfunction

  function automatic int s16(logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_prod = 0; m_acc = 0;
    m_aux = 0; m_yout = 0;
    m_busy = 0; m_sov = 0; m_band = 0;
    exp_q.delete();
  endtask

  task automatic drive(bit mv, int m, int c, int f, int a,
                       bit s, bit bl);
    int k, np, na;
    bit bn;
    bus.muestra        = 16'(m);
    bus.muestra_valida = mv;
    bus.sel_const      = 3'(c);
    bus.sel_fun        = 2'(f);
    bus.sel_acum       = 2'(a);
    bus.Senal          = s;
    bus.Band_Listo     = bl;
    bn = 0;
    if (!m_busy) begin
      if (mv) begin
        m_x = s16(16'(m));
        m_busy = 1;
        bn = 1;
      end
    end else begin
      k = ktab[c];
      case (f)
        0: np = k;
        1: np = mulq(m_acc, k);
        2: np = mulq(m_x, k);
        default: np = mulq(m_prod, k);
      endcase
      case (a)
        0: na = fix16(longint'(m_acc) + longint'(m_prod));
        1: na = m_prod;
        2: na = 0;
        default: na = m_acc;
      endcase
      if (s) m_aux = m_acc;
      if (mv) m_sov = 1;
      if (bl) begin
        m_busy = 0;
        m_yout = na;
        exp_q.push_back(na);
      end
      m_prod = np;
      m_acc = na;
    end
    m_band = bn;
    @(posedge clk);
    @(negedge clk);
    check("ocupado", int'(bus.ocupado), int'(m_busy));
    check("Bandera", int'(bus.Bandera), int'(m_band));
    check("sobrecarga", int'(bus.sobrecarga), int'(m_sov));
    check("y_aux", s16(bus.y_aux), m_aux);
    check("y_out", s16(bus.y_out), m_yout);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_y_out", s16(bus.y_out), 0);
    check("rst_y_aux", s16(bus.y_aux), 0);
    check("rst_flags", int'({bus.Bandera, bus.y_valida,
                             bus.ocupado, bus.sobrecarga}), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // scoreboard monitor: every y_valida pulse consumes one expectation
  always @(negedge clk) begin
    if (reset_n && bus.y_valida) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL y_valida_unexpected: got 1 expected 0");
      end else begin
        check("y_out_sb", s16(bus.y_out), exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    bus.muestra = '0;
    bus.muestra_valida = 0;
    bus.sel_const = '0;
    bus.sel_fun = '0;
    bus.sel_acum = 2'd3;
    bus.Senal = 0;
    bus.Band_Listo = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_y_out", s16(bus.y_out), 0);
    check("rst_flags", int'({bus.Bandera, bus.y_valida,
                             bus.ocupado, bus.sobrecarga}), 0);
    reset_n = 1'b1;
    idle();

    // basic run: x*K0 into prod, load acc, finish
    drive(1, 16'h0200, 0, 0, 3, 0, 0);
    drive(0, 0, 0, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 3, 0, 1);
    check("basic_y_out", s16(bus.y_out), 16'h0200);
    idle();
    idle();

    // accumulate twice: 0x0400 + 0x0400
    drive(1, 16'h0200, 0, 0, 3, 0, 0);
    drive(0, 0, 3, 2, 2, 0, 0);
    drive(0, 0, 3, 2, 0, 0, 0);
    drive(0, 0, 3, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 0, 1);
    check("accum_y_out", s16(bus.y_out), 16'h0800);
    idle();

    // overflow of x*K3
    drive(1, 16'h7000, 0, 0, 3, 0, 0);
    drive(0, 0, 3, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
`ifdef DATAPATH_SAT_EN
    check("sat_y_out", s16(bus.y_out), 32767);
`else
    check("wrap_y_out", s16(bus.y_out), s16(16'hE000));
`endif
    idle();

    // Band_Listo in IDLE is ignored
    drive(0, 0, 0, 0, 0, 0, 1);
    idle();

    // overrun: second sample dropped, sticky flag
    drive(1, 16'h0100, 0, 0, 3, 0, 0);
    drive(1, 16'h0300, 0, 2, 3, 0, 0);
    drive(0, 0, 0, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    check("overrun_x", s16(bus.y_out), 16'h0100);
    idle();
    check("sov_sticky", int'(bus.sobrecarga), 1);

    // snapshot and out-of-range constant
    drive(1, 16'h0180, 0, 0, 3, 0, 0);
    drive(0, 0, 0, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 7, 0, 3, 1, 0);
    check("snap_y_aux", s16(bus.y_aux), 16'h0180);
    drive(0, 0, 0, 0, 1, 0, 1);
    check("k7_zero", s16(bus.y_out), 0);
    idle();

    // simultaneous sample and finish
    drive(1, 16'h0040, 0, 0, 3, 0, 0);
    drive(0, 0, 0, 2, 1, 0, 0);
    drive(1, 16'h1111, 1, 2, 1, 0, 1);
    idle();

    // reset mid-sequence, then a clean run
    drive(1, 16'h0300, 0, 0, 3, 0, 0);
    drive(0, 0, 0, 2, 1, 0, 0);
    do_reset();
    idle();
    drive(1, 16'h0300, 0, 0, 3, 0, 0);
    drive(0, 0, 1, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    check("post_rst_y", s16(bus.y_out), 16'h0180);
    idle();

    // randomized runs
    for (int it = 0; it < 60; it++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++)
        drive(0, $urandom_range(0, 65535), $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      drive(1, $urandom_range(0, 65535), 0, 0, 3, 0, 0);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++)
        drive(($urandom_range(0, 7) == 0), $urandom_range(0, 65535),
              $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), 0);
      if ($urandom_range(0, 14) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 7) == 0), $urandom_range(0, 65535),
              $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), 1);
      end
    end

    repeat (3) idle();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
